// File: rtl/uxn_stack_engine_if.sv
// rtl/uxn_stack_engine_if.sv - op request handshake between core decode/ALU stage and stack engine
// Purpose: carries one stack op (pop/push description plus push bytes) with a valid/ready handshake.
// Ports (modports):
//   master : drives op_valid, op_pop_stk, op_pop_cnt, op_push_stk, op_push_cnt, op_keep, op_data; samples op_ready
//   slave  : samples the op fields; drives op_ready
interface uxn_stack_engine_if #(
  parameter int DATA_W    = 8,
  parameter int MAX_BYTES = 6,
  parameter int SEL_W     = 1
);
  logic                        op_valid;
  logic                        op_ready;
  logic [SEL_W-1:0]            op_pop_stk;
  logic [2:0]                  op_pop_cnt;
  logic [SEL_W-1:0]            op_push_stk;
  logic [2:0]                  op_push_cnt;
  logic                        op_keep;
  logic [MAX_BYTES*DATA_W-1:0] op_data;

  modport master (
    output op_valid, op_pop_stk, op_pop_cnt, op_push_stk, op_push_cnt, op_keep, op_data,
    input  op_ready
  );

  modport slave (
    input  op_valid, op_pop_stk, op_pop_cnt, op_push_stk, op_push_cnt, op_keep, op_data,
    output op_ready
  );
endinterface

// File: rtl/uxn_stack_engine.sv
// rtl/uxn_stack_engine.sv - multi-stack storage engine: atomic pop/push ops with under/overflow detection
// Purpose: holds NSTACK stacks of DEPTH cells; each accepted op pops up to MAX_BYTES cells from one
//   stack and pushes up to MAX_BYTES cells onto the same or another stack, one cell written per cycle.
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous reset, active-low
//   op_if      slave side of the op handshake (op_valid/op_ready plus op fields)
//   top_data   per stack, top MAX_BYTES cells (byte 0 = top), zero beyond current depth
//   depth      per stack occupancy in cells
//   done       one-cycle pulse when an op completes or is rejected
//   err_valid  one-cycle pulse alongside done for a rejected op
//   err_code   01 underflow, 10 overflow; holds the last reported error
module uxn_stack_engine #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 256,
  parameter int NSTACK    = 2,
  parameter int MAX_BYTES = 6,
  parameter int CNT_W     = $clog2(DEPTH + 1),
  parameter int SEL_W     = (NSTACK > 1) ? $clog2(NSTACK) : 1
) (
  input  logic                               clk,
  input  logic                               rst,
  uxn_stack_engine_if.slave                  op_if,
  output logic [NSTACK*MAX_BYTES*DATA_W-1:0] top_data,
  output logic [NSTACK*CNT_W-1:0]            depth,
  output logic                               done,
  output logic                               err_valid,
  output logic [1:0]                         err_code
);

  localparam int          AW   = $clog2(DEPTH);
  localparam int          XW   = CNT_W + 1;
  localparam logic [2:0]  MAXB = 3'(MAX_BYTES);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_COMMIT} state_e;

  state_e                      state_q, state_d;
  logic [CNT_W-1:0]            depth_q [NSTACK];
  logic [CNT_W-1:0]            depth_d [NSTACK];
  logic [SEL_W-1:0]            pop_stk_q, pop_stk_d, push_stk_q, push_stk_d;
  logic [2:0]                  pop_cnt_q, pop_cnt_d, push_cnt_q, push_cnt_d;
  logic [2:0]                  wcnt_q, wcnt_d;
  logic                        keep_q, keep_d;
  logic [MAX_BYTES*DATA_W-1:0] data_q, data_d;
  logic [1:0]                  pend_err_q, pend_err_d;
  logic [AW-1:0]               wbase_q, wbase_d;
  logic [1:0]                  err_code_q, err_code_d;

  logic [DATA_W-1:0]           mem_q [NSTACK][DEPTH];
  logic                        mem_we;
  logic [SEL_W-1:0]            mem_wstk;
  logic [AW-1:0]               mem_waddr;
  logic [DATA_W-1:0]           mem_wdata;

  // Accept-time error evaluation, all at CNT_W+1 bits so nothing wraps.
  logic [2:0]    pop_cnt_c, push_cnt_c, wr_idx;
  logic [XW-1:0] pd_x, dd_x, base_x, tgt_x;
  logic          same_stk, underflow, overflow;

  always_comb begin
    pop_cnt_c  = (op_if.op_pop_cnt  > MAXB) ? MAXB : op_if.op_pop_cnt;
    push_cnt_c = (op_if.op_push_cnt > MAXB) ? MAXB : op_if.op_push_cnt;
    same_stk   = (op_if.op_pop_stk == op_if.op_push_stk);
    pd_x       = XW'(depth_q[op_if.op_pop_stk]);
    dd_x       = XW'(depth_q[op_if.op_push_stk]);
    base_x     = op_if.op_keep ? pd_x : pd_x - XW'(pop_cnt_c);
    // Same-stack pushes land on top of what survives the pop; cross-stack on top of the target.
    tgt_x      = same_stk ? base_x : dd_x;
    underflow  = XW'(pop_cnt_c) > pd_x;
    overflow   = (tgt_x + XW'(push_cnt_c)) > XW'(DEPTH);
  end

  always_comb begin
    state_d    = state_q;
    pop_stk_d  = pop_stk_q;
    pop_cnt_d  = pop_cnt_q;
    push_stk_d = push_stk_q;
    push_cnt_d = push_cnt_q;
    wcnt_d     = wcnt_q;
    keep_d     = keep_q;
    data_d     = data_q;
    pend_err_d = pend_err_q;
    wbase_d    = wbase_q;
    err_code_d = err_code_q;
    for (int s = 0; s < NSTACK; s++) depth_d[s] = depth_q[s];
    op_if.op_ready = 1'b0;
    done       = 1'b0;
    err_valid  = 1'b0;
    err_code   = err_code_q;
    mem_we     = 1'b0;
    mem_wstk   = push_stk_q;
    mem_waddr  = '0;
    mem_wdata  = '0;
    wr_idx     = push_cnt_q - 3'd1 - wcnt_q;

    case (state_q)
      S_IDLE: begin
        op_if.op_ready = 1'b1;
        if (op_if.op_valid) begin
          pop_stk_d  = op_if.op_pop_stk;
          pop_cnt_d  = pop_cnt_c;
          push_stk_d = op_if.op_push_stk;
          push_cnt_d = push_cnt_c;
          keep_d     = op_if.op_keep;
          data_d     = op_if.op_data;
          wbase_d    = tgt_x[AW-1:0];
          wcnt_d     = 3'd0;
          pend_err_d = underflow ? 2'b01 : (overflow ? 2'b10 : 2'b00);
          state_d    = (underflow || overflow || push_cnt_c == 3'd0) ? S_COMMIT : S_WRITE;
        end
      end
      S_WRITE: begin
        // Deepest byte first so the last write is the new top of stack.
        mem_we    = 1'b1;
        mem_waddr = wbase_q + AW'(wcnt_q);
        mem_wdata = data_q[int'(wr_idx)*DATA_W +: DATA_W];
        wcnt_d    = wcnt_q + 3'd1;
        if (wcnt_q == push_cnt_q - 3'd1) state_d = S_COMMIT;
      end
      S_COMMIT: begin
        done    = 1'b1;
        state_d = S_IDLE;
        if (pend_err_q != 2'b00) begin
          err_valid  = 1'b1;
          err_code   = pend_err_q;
          err_code_d = pend_err_q;
        end else begin
          // Pop then push on each stack so a same-stack op composes into a single update.
          for (int s = 0; s < NSTACK; s++) begin
            if (SEL_W'(s) == pop_stk_q && !keep_q)
              depth_d[s] = depth_d[s] - CNT_W'(pop_cnt_q);
            if (SEL_W'(s) == push_stk_q)
              depth_d[s] = depth_d[s] + CNT_W'(push_cnt_q);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      for (int s = 0; s < NSTACK; s++) depth_q[s] <= '0;
      pop_stk_q  <= '0;
      pop_cnt_q  <= '0;
      push_stk_q <= '0;
      push_cnt_q <= '0;
      wcnt_q     <= '0;
      keep_q     <= 1'b0;
      data_q     <= '0;
      pend_err_q <= 2'b00;
      wbase_q    <= '0;
      err_code_q <= 2'b00;
    end else begin
      state_q    <= state_d;
      for (int s = 0; s < NSTACK; s++) depth_q[s] <= depth_d[s];
      pop_stk_q  <= pop_stk_d;
      pop_cnt_q  <= pop_cnt_d;
      push_stk_q <= push_stk_d;
      push_cnt_q <= push_cnt_d;
      wcnt_q     <= wcnt_d;
      keep_q     <= keep_d;
      data_q     <= data_d;
      pend_err_q <= pend_err_d;
      wbase_q    <= wbase_d;
      err_code_q <= err_code_d;
    end
  end

  // Cell storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_wstk][mem_waddr] <= mem_wdata;
  end

  for (genvar s = 0; s < NSTACK; s++) begin : g_stk
    assign depth[s*CNT_W +: CNT_W] = depth_q[s];
    for (genvar k = 0; k < MAX_BYTES; k++) begin : g_byte
      logic [AW-1:0] rd_idx;
      // Low AW bits suffice: a full stack (depth == DEPTH) wraps to DEPTH-1-k correctly.
      assign rd_idx = depth_q[s][AW-1:0] - AW'(k + 1);
      assign top_data[(s*MAX_BYTES + k)*DATA_W +: DATA_W] =
        (CNT_W'(k) < depth_q[s]) ? mem_q[s][rd_idx] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && op_if.op_valid && op_if.op_ready)
      assert (op_if.op_pop_cnt <= MAXB && op_if.op_push_cnt <= MAXB);
  end

endmodule
